// File: rtl/prog_loader.sv
// Boot-time program loader: assembles UART bytes into big-endian words,
// writes them to IMEM and answers with a single ACK byte.
module prog_loader #(
    parameter int                  DATAW_IN  = 8,
    parameter int                  DATAW_OUT = 32,
    parameter int                  ADDR_W    = 12,
    parameter logic [DATAW_IN-1:0] ACK_BYTE  = 8'hAA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rx_valid,
    input  logic [DATAW_IN-1:0]  rx_data,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATAW_OUT-1:0] wr_data,
    output logic                 tx_valid,
    output logic [DATAW_IN-1:0]  tx_data,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int NB  = DATAW_OUT / DATAW_IN;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW  = DATAW_OUT - DATAW_IN;
    localparam logic [32:0] MAX_LEN = 33'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_ACK, S_DONE, S_ERR
    } state_t;

    state_t state, state_nxt;

    logic [BCW-1:0]       byte_cnt;
    logic [PW-1:0]        part;
    logic [31:0]          word_cnt;
    logic [31:0]          len_q;
    logic [DATAW_OUT-1:0] word_nxt;
    logic                 can_start;
    logic                 byte_fire;
    logic                 word_fire;
    logic                 last_word;

    assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign byte_fire = rx_valid && ((state == S_LEN) || (state == S_DATA));
    assign word_fire = byte_fire && (byte_cnt == BCW'(NB - 1));
    assign word_nxt  = {part, rx_data};
    // Full-width compare so N = 2**ADDR_W finishes without address wrap.
    assign last_word = (word_cnt + 32'd1) == len_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (word_fire) begin
                    if (word_nxt == '0)                 state_nxt = S_ACK;
                    else if (33'(word_nxt) > MAX_LEN)   state_nxt = S_ERR;
                    else                                state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (word_fire && last_word) state_nxt = S_ACK;
            end
            S_ACK: begin
                if (tx_ready) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_valid = (state == S_ACK);
        tx_data  = ACK_BYTE;
        busy     = (state == S_LEN) || (state == S_DATA) || (state == S_ACK);
        done     = (state == S_DONE);
        err      = (state == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            part     <= '0;
            word_cnt <= '0;
            len_q    <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (can_start && start) begin
                byte_cnt <= '0;
                part     <= '0;
                word_cnt <= '0;
                len_q    <= '0;
            end else if (byte_fire) begin
                part     <= word_nxt[PW-1:0];
                byte_cnt <= word_fire ? '0 : byte_cnt + 1'b1;
                if (word_fire && (state == S_LEN))
                    len_q <= 32'(word_nxt);
                if (word_fire && (state == S_DATA)) begin
                    wr_en    <= 1'b1;
                    wr_addr  <= word_cnt[ADDR_W-1:0];
                    wr_data  <= word_nxt;
                    word_cnt <= word_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of load scenarios plus randomized loads,
// checked against a byte-list reference model of the expected IMEM image.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        err;

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t got[$];
    int  tx_cnt = 0;

    // Observed IMEM writes and ACK handshakes.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (wr_en === 1'b1) got.push_back('{wr_addr, wr_data});
            if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, {27'd0, wr_en, tx_valid, busy, done, err}, 32'd0);
        check({tag, "_addr"}, {20'd0, wr_addr}, 32'd0);
        check({tag, "_data"}, wr_data, 32'd0);
    endtask

    task automatic run_load(input logic [31:0] n, input int delay,
                            input bit noise, input bit exp_err,
                            input int exp_wr);
        logic [7:0]  data[$];
        logic [31:0] exp_w[$];
        int base, txb, bad, cyc, nd;
        base = got.size();
        txb  = tx_cnt;
        if (noise) begin
            repeat (3) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
                tick();
            end
        end
        start    = 1'b1;
        rx_valid = noise;
        rx_data  = 8'hFF;
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_clr", {30'd0, done, err}, 32'd0);
        for (int b = 0; b < 4; b++) data.push_back(n[31-8*b -: 8]);
        nd = exp_err ? 4 : 4 * int'(n);
        for (int i = 0; i < nd; i++) data.push_back(8'($urandom));
        if (!exp_err)
            for (int w = 0; w < int'(n); w++)
                exp_w.push_back({data[4+4*w], data[5+4*w],
                                 data[6+4*w], data[7+4*w]});
        for (int i = 0; i < data.size(); i++) begin
            rx_valid = 1'b1;
            rx_data  = data[i];
            tick();
            rx_valid = 1'b0;
            if (i == 7 && !exp_err) check("wr_latency", {31'd0, wr_en}, 32'd1);
            if (noise && i == 5 && !exp_err) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                tick();
            end
        end
        if (exp_err) begin
            repeat (3) tick();
            check("err_state", {29'd0, err, busy, tx_valid}, 32'h4);
        end else begin
            cyc = 0;
            while (tx_valid !== 1'b1 && cyc < 20) begin
                tick();
                cyc++;
            end
            check("ack_offer", {31'd0, tx_valid}, 32'd1);
            for (int d = 0; d < delay; d++) begin
                check("ack_hold", {23'd0, tx_valid, tx_data}, 32'h1AA);
                tick();
            end
            check("pre_hs_done", {31'd0, done}, 32'd0);
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            check("post_hs", {29'd0, done, busy, tx_valid}, 32'h4);
        end
        if (noise) begin
            repeat (3) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
                tick();
            end
            rx_valid = 1'b0;
            tick();
        end
        tick();
        check("wr_count", 32'(got.size() - base), 32'(exp_wr));
        check("tx_count", 32'(tx_cnt - txb), exp_err ? 32'd0 : 32'd1);
        bad = 0;
        for (int w = 0; w < exp_w.size() && base + w < got.size(); w++)
            if (got[base+w].a !== 12'(w) || got[base+w].d !== exp_w[w]) bad++;
        check("wr_words", 32'(bad), 32'd0);
    endtask

    typedef struct {
        logic [31:0] n;
        int          delay;
        bit          noise;
        bit          exp_err;
        int          exp_wr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] rn;
        bit          re;
        vecs = '{
            '{32'd2,       0, 1'b0, 1'b0, 2},
            '{32'd0,       0, 1'b0, 1'b0, 0},
            '{32'h00001001, 0, 1'b0, 1'b1, 0},
            '{32'd1,       5, 1'b0, 1'b0, 1},
            '{32'd3,       2, 1'b1, 1'b0, 3},
            '{32'd4096,    1, 1'b0, 1'b0, 4096},
            '{32'd4097,    0, 1'b1, 1'b1, 0}
        };
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++)
            run_load(vecs[i].n, vecs[i].delay, vecs[i].noise,
                     vecs[i].exp_err, vecs[i].exp_wr);

        // Reset two bytes into word 0, then a clean reload.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1;
            rx_data  = (i == 3) ? 8'h01 : (i < 3 ? 8'h00 : 8'h5A);
            tick();
        end
        rx_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        run_load(32'd1, 0, 1'b0, 1'b0, 1);

        repeat (20) begin
            re = ($urandom_range(0, 4) == 0);
            rn = re ? 32'(4097 + $urandom_range(0, 1000))
                    : 32'($urandom_range(0, 6));
            run_load(rn, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     re, re ? 0 : int'(rn));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
